nes_button_conditioner: RTL

//  Sits between NesReader and its consumers (clock_driver, vgaOutput, topLevel glue).

---
 rtl/nes_button_conditioner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nes_button_conditioner.sv
// Debounces eight raw NES button levels into held levels, press strobes and typematic repeat strobes.
// Level/strobes register D cycles after a stable raw change; no backpressure, strobes are single-cycle.
module nes_button_conditioner #(
    parameter int           DEBOUNCE_CYCLES = 500000,
    parameter int           HOLD_CYCLES     = 25000000,
    parameter int           REPEAT_CYCLES   = 5000000,
    parameter logic [7:0]   REPEAT_MASK     = 8'h0F
) (
    input  logic       clock50MHz,
    input  logic       reset,
    input  logic [7:0] btnRaw,
    output logic [7:0] btnLevel,
    output logic [7:0] btnPress,
    output logic [7:0] btnPulse
);

    localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES);
    localparam logic [RP_W-1:0] RP_ONE    = RP_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rp_state_t;

    for (genvar i = 0; i < 8; i++) begin : g_chan
        localparam bit RPT_EN = REPEAT_MASK[i];

        logic            level_q;
        logic            level_next;
        logic            press_q;
        logic            press_next;
        logic            pulse_q;
        logic            pulse_next;
        logic            fire;
        logic [DB_W-1:0] db_cnt;
        logic [DB_W-1:0] db_cnt_next;
        logic [RP_W-1:0] rp_cnt;
        logic [RP_W-1:0] rp_cnt_next;
        rp_state_t       state;
        rp_state_t       state_next;

        // Debounce: level only follows raw after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            level_next  = level_q;
            db_cnt_next = '0;
            if (btnRaw[i] != level_q) begin
                if (db_cnt == DB_LAST) begin
                    level_next = btnRaw[i];
                end else begin
                    db_cnt_next = db_cnt + DB_ONE;
                end
            end
        end

        always_ff @(posedge clock50MHz) begin
            if (reset) begin
                level_q <= 1'b0;
                press_q <= 1'b0;
                pulse_q <= 1'b0;
                db_cnt  <= '0;
                rp_cnt  <= '0;
                state   <= IDLE;
            end else begin
                level_q <= level_next;
                press_q <= press_next;
                pulse_q <= pulse_next;
                db_cnt  <= db_cnt_next;
                rp_cnt  <= rp_cnt_next;
                state   <= state_next;
            end
        end

        // Unmasked channels park in HOLD without counting so rp_cnt never overruns.
        always_comb begin
            state_next  = state;
            rp_cnt_next = rp_cnt;
            case (state)
                IDLE: begin
                    if (press_next) begin
                        state_next  = HOLD;
                        rp_cnt_next = RP_ONE;
                    end
                end
                HOLD: begin
                    if (!level_next) begin
                        state_next  = IDLE;
                        rp_cnt_next = '0;
                    end else if (RPT_EN) begin
                        if (rp_cnt == HOLD_LAST) begin
                            state_next  = REPEAT;
                            rp_cnt_next = RP_ONE;
                        end else begin
                            rp_cnt_next = rp_cnt + RP_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!level_next) begin
                        state_next  = IDLE;
                        rp_cnt_next = '0;
                    end else if (rp_cnt == REP_LAST) begin
                        rp_cnt_next = RP_ONE;
                    end else begin
                        rp_cnt_next = rp_cnt + RP_ONE;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    rp_cnt_next = '0;
                end
            endcase
        end

        always_comb begin
            press_next = level_next & ~level_q;
            fire       = 1'b0;
            if (level_next) begin
                if (state == HOLD && RPT_EN && rp_cnt == HOLD_LAST) begin
                    fire = 1'b1;
                end else if (state == REPEAT && rp_cnt == REP_LAST) begin
                    fire = 1'b1;
                end
            end
            pulse_next = press_next | fire;
        end

        assign btnLevel[i] = level_q;
        assign btnPress[i] = press_q;
        assign btnPulse[i] = pulse_q;
    end

endmodule
